// File: rtl/chacha_stream_if.sv
// Byte-wide host port of the ChaCha keystream engine.
//   data_in  : input-state byte, little-endian, word 0 byte 0 first
//   wr       : write strobe for data_in
//   rd       : pop the current output byte (only honoured while ready)
//   data_out : current output byte
//   ready    : a complete keystream block is available
//   busy     : engine is copying, computing, summing or incrementing
//   ctr_wrap : sticky flag, block counter overflowed on auto-increment
// master = host side, slave = engine side.
interface chacha_stream_if;
    logic [7:0] data_in;
    logic       wr;
    logic       rd;
    logic [7:0] data_out;
    logic       ready;
    logic       busy;
    logic       ctr_wrap;

    modport master (
        output data_in, wr, rd,
        input  data_out, ready, busy, ctr_wrap
    );

    modport slave (
        input  data_in, wr, rd,
        output data_out, ready, busy, ctr_wrap
    );
endinterface

// File: rtl/chacha_stream_block.sv
// ChaCha keystream engine with byte-serial load and byte-serial readout.
// A 16x32 input state is written one byte at a time; writing byte 63 starts
// a block: one quarter-round per cycle, then the feed-forward add. The 64-byte
// result is popped one byte per rd. With AUTO_INC the counter field of the
// input state is incremented after the last byte and the next block starts
// without a reload.
// Ports:
//   clk   : clock
//   rst_n : synchronous active-low reset
//   bus   : chacha_stream_if.slave (data_in, wr, rd, data_out, ready, busy, ctr_wrap)
// Parameters:
//   ROUNDS    : total rounds (8, 12 or 20); CALC takes 4*ROUNDS cycles
//   CTR_WORDS : 1 = counter is s12, 2 = counter is s13:s12 (s12 low)
//   AUTO_INC  : 1 = increment counter and regenerate after the last read
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | nothing loaded or block consumed without auto-increment
// LOAD   | receiving input-state bytes
// COPY   | working state <= input state
// CALC   | one quarter-round per cycle, 4*ROUNDS cycles
// SUM    | working state += input state (feed-forward)
// READY  | block available, bytes popped by rd
// INC    | counter field of input state incremented, then COPY
module chacha_stream_block #(
    parameter int ROUNDS    = 20,
    parameter int CTR_WORDS = 1,
    parameter int AUTO_INC  = 1
) (
    input  logic clk,
    input  logic rst_n,
    chacha_stream_if.slave bus
);

    localparam int NQR = 4 * ROUNDS;
    localparam int RCW = $clog2(NQR);
    localparam logic [RCW-1:0] RC_LAST = RCW'(NQR - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_COPY, S_CALC, S_SUM, S_READY, S_INC
    } state_t;

    state_t         state;
    logic [31:0]    in_st [16];
    logic [31:0]    w     [16];
    logic [5:0]     in_idx;
    logic [5:0]     out_idx;
    logic [RCW-1:0] rnd_cnt;
    logic           ready_r;
    logic           busy_r;
    logic           wrap_r;

    // Quarter-round operand selection. Bit 2 of rnd_cnt is the round parity:
    // even rounds use columns, odd rounds use diagonals, which shift the
    // b/c/d rows by 1/2/3 positions (mod 4).
    logic [1:0] q, qb, qc, qd;
    logic       diag;
    logic [3:0] ia, ib, ic, id;

    always_comb begin
        q    = rnd_cnt[1:0];
        diag = rnd_cnt[2];
        qb   = q + {1'b0, diag};
        qc   = q + {diag, 1'b0};
        qd   = q + {diag, diag};
        ia   = {2'b00, q};
        ib   = {2'b01, qb};
        ic   = {2'b10, qc};
        id   = {2'b11, qd};
    end

    logic [31:0] a0, b0, c0, d0;
    logic [31:0] a1, b1, c1, d1, t_d1, t_b1;
    logic [31:0] a2, b2, c2, d2, t_d2, t_b2;

    always_comb begin
        a0   = w[ia];
        b0   = w[ib];
        c0   = w[ic];
        d0   = w[id];
        a1   = a0 + b0;
        t_d1 = d0 ^ a1;
        d1   = {t_d1[15:0], t_d1[31:16]};
        c1   = c0 + d1;
        t_b1 = b0 ^ c1;
        b1   = {t_b1[19:0], t_b1[31:20]};
        a2   = a1 + b1;
        t_d2 = d1 ^ a2;
        d2   = {t_d2[23:0], t_d2[31:24]};
        c2   = c1 + d2;
        t_b2 = b1 ^ c2;
        b2   = {t_b2[24:0], t_b2[31:25]};
    end

    // Counter field: 32-bit uses s12 only; 64-bit carries into s13.
    logic [63:0] ctr_cur;
    logic [63:0] ctr_nxt;
    logic        ctr_ovf;

    always_comb begin
        if (CTR_WORDS == 2) begin
            ctr_cur = {in_st[13], in_st[12]};
            ctr_ovf = &ctr_cur;
        end else begin
            ctr_cur = {32'd0, in_st[12]};
            ctr_ovf = &ctr_cur[31:0];
        end
        ctr_nxt = ctr_cur + 64'd1;
    end

    assign bus.data_out = ready_r ? w[out_idx[5:2]][{out_idx[1:0], 3'b000} +: 8] : 8'h00;
    assign bus.ready    = ready_r;
    assign bus.busy     = busy_r;
    assign bus.ctr_wrap = wrap_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            in_idx  <= '0;
            out_idx <= '0;
            rnd_cnt <= '0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            wrap_r  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                in_st[i] <= '0;
                w[i]     <= '0;
            end
        end else if (bus.wr) begin
            if (state == S_IDLE || state == S_LOAD) begin
                in_st[in_idx[5:2]][{in_idx[1:0], 3'b000} +: 8] <= bus.data_in;
                if (in_idx == 6'd0) begin
                    wrap_r <= 1'b0;
                end
                if (in_idx == 6'd63) begin
                    in_idx <= '0;
                    state  <= S_COPY;
                    busy_r <= 1'b1;
                end else begin
                    in_idx <= in_idx + 6'd1;
                    state  <= S_LOAD;
                end
            end else begin
                // A write outside loading abandons the current block and is
                // taken as byte 0 of a fresh input state.
                in_st[0][7:0] <= bus.data_in;
                in_idx        <= 6'd1;
                out_idx       <= '0;
                rnd_cnt       <= '0;
                state         <= S_LOAD;
                ready_r       <= 1'b0;
                busy_r        <= 1'b0;
                wrap_r        <= 1'b0;
            end
        end else begin
            case (state)
                S_COPY: begin
                    for (int i = 0; i < 16; i++) begin
                        w[i] <= in_st[i];
                    end
                    rnd_cnt <= '0;
                    state   <= S_CALC;
                end
                S_CALC: begin
                    w[ia] <= a2;
                    w[ib] <= b2;
                    w[ic] <= c2;
                    w[id] <= d2;
                    if (rnd_cnt == RC_LAST) begin
                        rnd_cnt <= '0;
                        state   <= S_SUM;
                    end else begin
                        rnd_cnt <= rnd_cnt + 1'b1;
                    end
                end
                S_SUM: begin
                    for (int i = 0; i < 16; i++) begin
                        w[i] <= w[i] + in_st[i];
                    end
                    out_idx <= '0;
                    state   <= S_READY;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
                S_READY: begin
                    if (bus.rd) begin
                        if (out_idx == 6'd63) begin
                            out_idx <= '0;
                            ready_r <= 1'b0;
                            if (AUTO_INC != 0) begin
                                state  <= S_INC;
                                busy_r <= 1'b1;
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            out_idx <= out_idx + 6'd1;
                        end
                    end
                end
                S_INC: begin
                    in_st[12] <= ctr_nxt[31:0];
                    if (CTR_WORDS == 2) begin
                        in_st[13] <= ctr_nxt[63:32];
                    end
                    if (ctr_ovf) begin
                        wrap_r <= 1'b1;
                    end
                    state <= S_COPY;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_stream_block.sv
// Bench for chacha_stream_block: four engines with different parameters share
// the host stimulus; sel picks which one sees wr/rd and whose outputs are
// observed. Expected keystream bytes come from an RFC 8439 style software
// model and are queued when a block is started, then popped as bytes are read.
module tb_chacha_stream_block;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_in;
    logic       wr;
    logic       rd;
    int         sel;

    always #5 clk = ~clk;

    chacha_stream_if if0 ();
    chacha_stream_if if1 ();
    chacha_stream_if if2 ();
    chacha_stream_if if3 ();

    assign if0.data_in = data_in;
    assign if1.data_in = data_in;
    assign if2.data_in = data_in;
    assign if3.data_in = data_in;
    assign if0.wr = wr && (sel == 0);
    assign if1.wr = wr && (sel == 1);
    assign if2.wr = wr && (sel == 2);
    assign if3.wr = wr && (sel == 3);
    assign if0.rd = rd && (sel == 0);
    assign if1.rd = rd && (sel == 1);
    assign if2.rd = rd && (sel == 2);
    assign if3.rd = rd && (sel == 3);

    chacha_stream_block #(.ROUNDS(20), .CTR_WORDS(1), .AUTO_INC(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    chacha_stream_block #(.ROUNDS(20), .CTR_WORDS(2), .AUTO_INC(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    chacha_stream_block #(.ROUNDS(8),  .CTR_WORDS(1), .AUTO_INC(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    chacha_stream_block #(.ROUNDS(12), .CTR_WORDS(2), .AUTO_INC(0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

    logic [7:0] dout_s;
    logic       ready_s, busy_s, wrap_s;

    always_comb begin
        dout_s  = if0.data_out;
        ready_s = if0.ready;
        busy_s  = if0.busy;
        wrap_s  = if0.ctr_wrap;
        case (sel)
            1: begin dout_s = if1.data_out; ready_s = if1.ready; busy_s = if1.busy; wrap_s = if1.ctr_wrap; end
            2: begin dout_s = if2.data_out; ready_s = if2.ready; busy_s = if2.busy; wrap_s = if2.ctr_wrap; end
            3: begin dout_s = if3.data_out; ready_s = if3.ready; busy_s = if3.busy; wrap_s = if3.ctr_wrap; end
            default: begin end
        endcase
    end

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_in [16];
    logic [31:0] mx   [16];
    logic [7:0]  sb   [$];
    logic [7:0]  got  [$];
    logic [7:0]  rfc16 [16] = '{8'h10, 8'hf1, 8'he7, 8'he4, 8'hd1, 8'h3b, 8'h59, 8'h15,
                                8'h50, 8'h0f, 8'hdd, 8'h1f, 8'ha3, 8'h20, 8'h71, 8'hc4};

    // ---------------- software model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic void qr(input int a, input int b, input int c, input int d);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 16);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 12);
        mx[a] = mx[a] + mx[b]; mx[d] = rotl(mx[d] ^ mx[a], 8);
        mx[c] = mx[c] + mx[d]; mx[b] = rotl(mx[b] ^ mx[c], 7);
    endfunction

    function automatic void push_model(input int rounds);
        logic [31:0] v;
        for (int i = 0; i < 16; i++) mx[i] = m_in[i];
        for (int r = 0; r < rounds / 2; r++) begin
            qr(0, 4, 8, 12); qr(1, 5, 9, 13); qr(2, 6, 10, 14); qr(3, 7, 11, 15);
            qr(0, 5, 10, 15); qr(1, 6, 11, 12); qr(2, 7, 8, 13); qr(3, 4, 9, 14);
        end
        for (int i = 0; i < 16; i++) begin
            v = mx[i] + m_in[i];
            for (int b = 0; b < 4; b++) sb.push_back(v[8*b +: 8]);
        end
    endfunction

    function automatic void rand_state();
        for (int i = 0; i < 16; i++) m_in[i] = $urandom;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr      = 1'b1;
        data_in = b;
        tick();
        wr      = 1'b0;
    endtask

    task automatic load_from(input int first);
        for (int i = first; i < 64; i++) wr_byte(m_in[i / 4][8 * (i % 4) +: 8]);
    endtask

    // Starts in the cycle after the triggering edge, so that cycle counts as 1.
    task automatic wait_ready(output int lat);
        lat = 1;
        while (!ready_s && lat < 400) begin
            tick();
            lat++;
        end
    endtask

    task automatic read_bytes(input int n);
        for (int i = 0; i < n; i++) begin
            got.push_back(dout_s);
            rd = 1'b1;
            tick();
        end
        rd = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; data_in = 8'h00; sel = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            n_checks++; if (ready_s !== 1'b0) $display("FAIL reset_ready dut%0d got %b exp 0", s, ready_s); else n_pass++;
            n_checks++; if (busy_s !== 1'b0) $display("FAIL reset_busy dut%0d got %b exp 0", s, busy_s); else n_pass++;
            n_checks++; if (dout_s !== 8'h00) $display("FAIL reset_dout dut%0d got %h exp 00", s, dout_s); else n_pass++;
            n_checks++; if (wrap_s !== 1'b0) $display("FAIL reset_wrap dut%0d got %b exp 0", s, wrap_s); else n_pass++;
        end
    endtask

    task automatic test_rfc_vector();
        int lat;
        sel = 0;
        m_in = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
                 32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
                 32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
                 32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
        push_model(20);
        load_from(0);
        n_checks++; if (busy_s !== 1'b1) $display("FAIL rfc_busy_copy got %b exp 1", busy_s); else n_pass++;
        wait_ready(lat);
        n_checks++; if (lat !== 83) $display("FAIL rfc_latency got %0d exp 83", lat); else n_pass++;
        n_checks++; if (busy_s !== 1'b0) $display("FAIL rfc_busy_ready got %b exp 0", busy_s); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (got[i] !== rfc16[i]) $display("FAIL rfc_known byte %0d got %h exp %h", i, got[i], rfc16[i]);
            else n_pass++;
        end
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL rfc_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_auto_inc();
        int lat;
        sel = 0;
        m_in[12] = 32'd2;
        push_model(20);
        wait_ready(lat);
        n_checks++; if (lat !== 84) $display("FAIL autoinc_latency got %0d exp 84", lat); else n_pass++;
        n_checks++; if (wrap_s !== 1'b0) $display("FAIL autoinc_wrap got %b exp 0", wrap_s); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL autoinc_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_ctr_wrap_32();
        int lat;
        sel = 0;
        rand_state();
        m_in[12] = 32'hffffffff;
        m_in[13] = 32'h0badcafe;
        push_model(20);
        load_from(0);
        wait_ready(lat);
        n_checks++; if (lat !== 83) $display("FAIL wrap32_latency got %0d exp 83", lat); else n_pass++;
        n_checks++; if (wrap_s !== 1'b0) $display("FAIL wrap32_flag_before got %b exp 0", wrap_s); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL wrap32_blk0 byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
        m_in[12] = 32'h0;
        push_model(20);
        wait_ready(lat);
        n_checks++; if (lat !== 84) $display("FAIL wrap32_latency2 got %0d exp 84", lat); else n_pass++;
        n_checks++; if (wrap_s !== 1'b1) $display("FAIL wrap32_flag got %b exp 1", wrap_s); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL wrap32_blk1 byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_calc();
        sel = 0;
        repeat (20) tick();
        n_checks++; if (busy_s !== 1'b1) $display("FAIL rstcalc_busy_pre got %b exp 1", busy_s); else n_pass++;
        rst_n = 1'b0;
        tick();
        n_checks++; if (ready_s !== 1'b0) $display("FAIL rstcalc_ready got %b exp 0", ready_s); else n_pass++;
        n_checks++; if (busy_s !== 1'b0) $display("FAIL rstcalc_busy got %b exp 0", busy_s); else n_pass++;
        n_checks++; if (dout_s !== 8'h00) $display("FAIL rstcalc_dout got %h exp 00", dout_s); else n_pass++;
        n_checks++; if (wrap_s !== 1'b0) $display("FAIL rstcalc_wrap got %b exp 0", wrap_s); else n_pass++;
        rst_n = 1'b1;
        repeat (100) tick();
        n_checks++; if ({ready_s, busy_s} !== 2'b00) $display("FAIL rstcalc_stays_idle got %b exp 00", {ready_s, busy_s}); else n_pass++;
    endtask

    task automatic test_ctr_wrap_64();
        int lat;
        sel = 1;
        rand_state();
        m_in[12] = 32'hffffffff;
        m_in[13] = 32'h12345678;
        push_model(20);
        load_from(0);
        wait_ready(lat);
        n_checks++; if (lat !== 83) $display("FAIL wrap64_latency got %0d exp 83", lat); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL wrap64_blk0 byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
        m_in[12] = 32'h0;
        m_in[13] = 32'h12345679;
        push_model(20);
        wait_ready(lat);
        n_checks++; if (lat !== 84) $display("FAIL wrap64_latency2 got %0d exp 84", lat); else n_pass++;
        n_checks++; if (wrap_s !== 1'b0) $display("FAIL wrap64_flag got %b exp 0", wrap_s); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL wrap64_blk1 byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_reduced_rounds();
        int lat;
        int rounds_tab [2] = '{8, 12};
        for (int k = 0; k < 2; k++) begin
            sel = 2 + k;
            rand_state();
            push_model(rounds_tab[k]);
            load_from(0);
            wait_ready(lat);
            n_checks++;
            if (lat !== 4 * rounds_tab[k] + 3) $display("FAIL r%0d_latency got %0d exp %0d", rounds_tab[k], lat, 4 * rounds_tab[k] + 3);
            else n_pass++;
            read_bytes(64);
            for (int i = 0; i < 64; i++) begin
                logic [7:0] e, o;
                e = sb.pop_front(); o = got.pop_front();
                n_checks++; if (o !== e) $display("FAIL r%0d_blk byte %0d got %h exp %h", rounds_tab[k], i, o, e); else n_pass++;
            end
            repeat (5) tick();
            n_checks++;
            if ({ready_s, busy_s} !== 2'b00) $display("FAIL r%0d_no_regen got %b exp 00", rounds_tab[k], {ready_s, busy_s});
            else n_pass++;
        end
    endtask

    task automatic test_abort_mid_calc();
        int lat;
        sel = 0;
        rand_state();
        load_from(0);
        repeat (41) tick();
        rand_state();
        push_model(20);
        wr_byte(m_in[0][7:0]);
        n_checks++; if (busy_s !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy_s); else n_pass++;
        n_checks++; if (ready_s !== 1'b0) $display("FAIL abort_ready got %b exp 0", ready_s); else n_pass++;
        load_from(1);
        wait_ready(lat);
        n_checks++; if (lat !== 83) $display("FAIL abort_latency got %0d exp 83", lat); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL abort_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    task automatic test_rd_ignored();
        int lat;
        // rd while busy
        sel = 0;
        rand_state();
        push_model(20);
        load_from(0);
        rd = 1'b1;
        repeat (10) tick();
        rd = 1'b0;
        wait_ready(lat);
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL rdbusy_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
        // rd while idle
        sel = 2;
        rd = 1'b1;
        repeat (5) tick();
        rd = 1'b0;
        rand_state();
        push_model(8);
        load_from(0);
        wait_ready(lat);
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL rdidle_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
        // rd+wr in READY: the write wins and restarts loading
        sel = 0;
        wait_ready(lat);
        n_checks++; if (ready_s !== 1'b1) $display("FAIL rdwr_pre_ready got %b exp 1", ready_s); else n_pass++;
        read_bytes(5);
        got.delete();
        rand_state();
        push_model(20);
        data_in = m_in[0][7:0];
        wr = 1'b1;
        rd = 1'b1;
        tick();
        wr = 1'b0;
        rd = 1'b0;
        n_checks++; if ({ready_s, busy_s} !== 2'b00) $display("FAIL rdwr_abort got %b exp 00", {ready_s, busy_s}); else n_pass++;
        load_from(1);
        wait_ready(lat);
        n_checks++; if (lat !== 83) $display("FAIL rdwr_latency got %0d exp 83", lat); else n_pass++;
        read_bytes(64);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] e, o;
            e = sb.pop_front(); o = got.pop_front();
            n_checks++; if (o !== e) $display("FAIL rdwr_blk byte %0d got %h exp %h", i, o, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rfc_vector();
        test_auto_inc();
        test_ctr_wrap_32();
        test_reset_mid_calc();
        test_ctr_wrap_64();
        test_reduced_rounds();
        test_abort_mid_calc();
        test_rd_ignored();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
